// File: rtl/croc_pkg.sv
// croc_pkg: SoC-wide constants and the OBI subordinate bundle types
// shared by the bank arbiter and the crossbar.
package croc_pkg;

  localparam int unsigned SramBankNumWords  = 512;
  localparam int unsigned SramBankAddrWidth = $clog2(SramBankNumWords);
  localparam int unsigned SramArbMaxBurst   = 4;
  localparam int unsigned SbrObiIdWidth     = 4;

  typedef struct packed {
    logic                     req;
    logic                     we;
    logic [3:0]               be;
    logic [31:0]              addr;
    logic [31:0]              wdata;
    logic [SbrObiIdWidth-1:0] aid;
  } sbr_obi_req_t;

  typedef struct packed {
    logic                     gnt;
    logic                     rvalid;
    logic [31:0]              rdata;
    logic [SbrObiIdWidth-1:0] rid;
    logic                     err;
    logic                     r_optional;
  } sbr_obi_rsp_t;

  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/croc_sram_bank_arb_if.sv
// croc_sram_bank_arb_if: the NumReq OBI subordinate ports that compete
// for one SRAM bank.
interface croc_sram_bank_arb_if #(
  parameter int unsigned NumReq = 2
);
  import croc_pkg::*;

  sbr_obi_req_t req [NumReq];
  sbr_obi_rsp_t rsp [NumReq];

  modport mst (output req, input rsp);
  modport slv (input req, output rsp);

endinterface

// File: rtl/croc_rr_burst_arb.sv
// croc_rr_burst_arb: round-robin arbiter that lets the last winner keep
// the grant for up to MaxBurst consecutive cycles.
module croc_rr_burst_arb
  import croc_pkg::*;
#(
  parameter int unsigned NumReq   = 2,
  parameter int unsigned MaxBurst = 4,
  localparam int unsigned IdxW    = idx_width(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o
);

  localparam int unsigned CntW = $clog2(MaxBurst + 1);

  logic [IdxW-1:0] owner_q, owner_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] j;
  logic            keep;

  assign keep = req_i[owner_q] && (cnt_q < CntW'(MaxBurst));

  // Scan from the far end so the nearest requester after owner wins.
  always_comb begin
    idx_o = owner_q;
    j     = '0;
    if (!keep) begin
      for (int k = NumReq; k >= 1; k--) begin
        j = IdxW'((int'(owner_q) + k) % NumReq);
        if (req_i[j]) idx_o = j;
      end
    end
  end

  assign gnt_o = (|req_i && !rst_i) ? (NumReq'(1) << idx_o) : '0;

  always_comb begin
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (!(|req_i)) begin
      cnt_d = '0;
    end else if (keep) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      owner_d = idx_o;
      cnt_d   = (NumReq == 1) ? CntW'(MaxBurst) : CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/croc_sram_bank_arb.sv
// croc_sram_bank_arb: shares one single-port SRAM bank between NumReq
// OBI ports; grant is combinational, response one cycle later.
module croc_sram_bank_arb
  import croc_pkg::*;
#(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned MaxBurst  = SramArbMaxBurst,
  parameter int unsigned NumWords  = SramBankNumWords,
  parameter int unsigned AddrWidth = SramBankAddrWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  croc_sram_bank_arb_if.slv    obi,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [31:0]          sram_wdata_o,
  output logic [3:0]           sram_be_o,
  input  logic [31:0]          sram_rdata_i
);

  localparam int unsigned IdxW = idx_width(NumReq);

  sbr_obi_req_t             req [NumReq];
  sbr_obi_rsp_t             rsp [NumReq];
  sbr_obi_req_t             win;
  logic [NumReq-1:0]        req_vec;
  logic [NumReq-1:0]        gnt;
  logic [IdxW-1:0]          idx;
  logic                     rvalid_q;
  logic [IdxW-1:0]          rsel_q;
  logic [SbrObiIdWidth-1:0] rid_q;
  logic                     unused_bits;

  for (genvar i = 0; i < NumReq; i++) begin : g_port
    assign req[i]     = obi.req[i];
    assign req_vec[i] = obi.req[i].req;
    assign obi.rsp[i] = rsp[i];
  end

  croc_rr_burst_arb #(
    .NumReq   (NumReq),
    .MaxBurst (MaxBurst)
  ) i_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (req_vec),
    .gnt_o (gnt),
    .idx_o (idx)
  );

  assign win          = req[idx];
  assign sram_req_o   = |req_vec && !rst_i;
  assign sram_we_o    = sram_req_o && win.we;
  assign sram_addr_o  = win.addr[AddrWidth+1:2];
  assign sram_wdata_o = win.wdata;
  assign sram_be_o    = win.be;

  // Bank is pre-decoded; upper and byte-offset bits carry nothing here.
  assign unused_bits = ^{win.addr[31:AddrWidth+2],
                         win.addr[1:0], win.req};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rsel_q   <= '0;
      rid_q    <= '0;
    end else begin
      rvalid_q <= sram_req_o;
      rsel_q   <= idx;
      rid_q    <= win.aid;
    end
  end

  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      rsp[i]     = '0;
      rsp[i].gnt = gnt[i];
      if (rvalid_q && !rst_i && rsel_q == IdxW'(i)) begin
        rsp[i].rvalid = 1'b1;
        rsp[i].rdata  = sram_rdata_i;
        rsp[i].rid    = rid_q;
      end
    end
  end

endmodule
